stream_rr_arb: RTL and testbench
================================

Name: stream_rr_arb

Overview:
Round-robin arbiter that shares one downstream consumer among NREQ upstream valid/stop streams. Each requester normally sits behind its own input skid buffer. The granted stream is passed combinationally to the consumer, so stop/valid semantics are preserved end to end. A grant is held for a whole packet (until last) or until MAXBURST beats, whichever comes first. The pointer then rotates past the served requester.

Parameters:
NREQ, 4, number of requesting streams (>=2)
MAXBURST, 16, max beats per grant before forced rotation (>=1)
(data width fixed at NUM+1 bits signed, NUM from def.svh)

Ports:
clk  input  1  clock, all logic on posedge
reset  input  1  synchronous, active-low reset (asserted when 0)
idata  input  [NREQ-1:0][NUM:0] signed  per-requester data
ivalid  input  NREQ  per-requester valid
ilast  input  NREQ  per-requester end-of-packet flag, qualified by ivalid
istop  output  NREQ  per-requester stop (1 = do not advance)
cdata  output  [NUM:0] signed  data to consumer
cvalid  output  1  valid to consumer
clast  output  1  end-of-packet to consumer
cstop  input  1  consumer stop
grant_id  output  $clog2(NREQ)  currently granted requester (status)
busy  output  1  1 while in GRANT state

Behaviour:
- Transfer rule: a beat moves when valid=1 and stop=0 in the same cycle, on both sides.
- State: IDLE, GRANT. Registers: state, grant (index), ptr (next-priority index), cnt ($clog2(MAXBURST+1) bits).
- Reset (reset==0 at posedge): state<=IDLE, grant<=0, ptr<=0, cnt<=0.
- While reset==0, outputs are gated combinationally: istop all 1, cvalid 0.
- Reset mid-burst aborts the grant. No beat transfers in any cycle where reset==0.
- IDLE:
  - cvalid=0, clast=0, istop all 1, busy=0.
  - If any ivalid: the winner is the first i with ivalid[i]=1, searching ptr, ptr+1, ... with wrap modulo NREQ.
  - On a win: grant<=winner, cnt<=0, state<=GRANT.
  - No ivalid: stay in IDLE.
- GRANT:
  - cdata=idata[grant], cvalid=ivalid[grant], clast=ilast[grant].
  - istop[grant]=cstop. istop[j]=1 for every j!=grant. busy=1.
- End of grant: on a transfer with ilast[grant]=1, or on a transfer where cnt==MAXBURST-1:
  - state<=IDLE, cnt<=0.
  - ptr<=grant+1, wrapping to 0 when grant==NREQ-1.
- Otherwise, each transfer increments cnt.
- No transfer: hold state. The requester may deassert ivalid while granted; the grant is held (no timeout).
- Forced rotation at MAXBURST does not assert clast. clast is always the requester's own ilast. The packet resumes on that requester's next grant.
- Latency:
  - Arbitration costs 1 cycle: a request seen in IDLE at cycle t is first forwardable at t+1.
  - Exactly one IDLE bubble between consecutive grants.
  - Data path is 0-latency combinational in GRANT.
- Fairness: a continuously requesting input waits at most (NREQ-1) grants.
- MAXBURST==1: every grant carries exactly one beat.
- Simultaneous ilast and cnt==MAXBURST-1: a single end-of-grant, same update as above.
- grant_id=grant in both states. It is meaningful only when busy=1.

Decomposition:
- def.svh (shared): NUM, plus the arbiter state enum typedef (ARB_IDLE, ARB_GRANT) for reuse by other sequencers.
- Sub-module rr_pick: purely combinational rotating-priority finder.
  - Inputs: req[NREQ], ptr.
  - Outputs: any, idx.
  - It is instantiated once inside stream_rr_arb, which holds all sequential state.

Test Plan:
1. Reset hold: reset=0 for 3 cycles with all ivalid=1 -> istop=4'b1111, cvalid=0, busy=0. First cycle after release: IDLE decision, grant_id=0, busy=1 next cycle.
2. Round robin (NREQ=4, MAXBURST=16): all four send 1-beat packets (ilast=1) continuously with cstop=0 -> grant order 0,1,2,3,0,1. One bubble between grants, so a beat every 2 cycles.
3. Packet lock: req1 sends 3 beats (10,11,12, last on 12) while req2 is valid throughout -> cdata 10,11,12 contiguous with clast only on 12. Then bubble, then req2 is granted.
4. Backpressure: during a req0 grant, cstop=1 for 5 cycles -> istop[0]=1, cdata held stable from req0's side, cnt unchanged, no grant change. After release, the remaining beats flow.
5. Forced rotation (MAXBURST=4): req3 sends an 8-beat packet, req0 also valid -> 4 beats from req3 with clast=0, then req0 is served, then req3's remaining 4 beats with clast on beat 8.
6. Mid-burst reset: reset=0 during beat 2 of a req2 packet -> same cycle istop all 1 and cvalid=0. After release ptr=0, so req0 wins if valid.

Source files
------------

// File: rtl/stream_rr_arb_pkg.sv
// Shared definitions for the stream arbiter and other sequencers:
// datapath width and the arbiter state encoding.
package stream_rr_arb_pkg;

    // Data words are NUM+1 bits, signed.
    localparam int NUM = 15;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_GRANT = 1'b1
    } arb_state_t;

endpackage

// File: rtl/stream_rr_arb_rr_pick.sv
// Rotating-priority finder: returns the first asserted request at or after
// ptr, wrapping modulo NREQ. Purely combinational.
module rr_pick
    import stream_rr_arb_pkg::*;
#(
    parameter int NREQ = 4,
    localparam int PW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic            any,
    output logic [PW-1:0]   idx
);

    // Walk offsets from farthest to nearest so the nearest hit to ptr wins.
    always_comb begin
        any = |req;
        idx = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req[PW'((int'(ptr) + k) % NREQ)]) begin
                idx = PW'((int'(ptr) + k) % NREQ);
            end
        end
    end

endmodule

// File: rtl/stream_rr_arb.sv
// Round-robin arbiter sharing one valid/stop consumer among NREQ streams.
// The granted stream is forwarded combinationally; a grant lasts until the
// requester's last beat or MAXBURST beats, then priority rotates past it.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ARB_IDLE  | no owner; pick the next requester from ptr (1-cycle bubble)
// ARB_GRANT | grant owns the consumer until last beat or MAXBURST beats
module stream_rr_arb
    import stream_rr_arb_pkg::*;
#(
    parameter int NREQ     = 4,
    parameter int MAXBURST = 16,
    localparam int PW      = (NREQ > 1) ? $clog2(NREQ) : 1,
    localparam int CW      = $clog2(MAXBURST + 1)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic signed [NREQ-1:0][NUM:0] idata,
    input  logic [NREQ-1:0]               ivalid,
    input  logic [NREQ-1:0]               ilast,
    output logic [NREQ-1:0]               istop,
    output logic signed [NUM:0]           cdata,
    output logic                          cvalid,
    output logic                          clast,
    input  logic                          cstop,
    output logic [PW-1:0]                 grant_id,
    output logic                          busy
);

    arb_state_t    state_q, state_d;
    logic [PW-1:0] grant_q, grant_d;
    logic [PW-1:0] ptr_q, ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic          pick_any;
    logic [PW-1:0] pick_idx;
    logic          xfer;

    rr_pick #(.NREQ(NREQ)) u_pick (
        .req (ivalid),
        .ptr (ptr_q),
        .any (pick_any),
        .idx (pick_idx)
    );

    // Next-state, forwarding mux and stop fan-out; reset gates the handshake.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        cdata   = idata[grant_q];
        cvalid  = 1'b0;
        clast   = 1'b0;
        istop   = '1;
        busy    = 1'b0;
        xfer    = 1'b0;

        case (state_q)
            ARB_IDLE: begin
                if (pick_any) begin
                    grant_d = pick_idx;
                    cnt_d   = '0;
                    state_d = ARB_GRANT;
                end
            end
            ARB_GRANT: begin
                busy           = 1'b1;
                cvalid         = ivalid[grant_q];
                clast          = ilast[grant_q];
                istop[grant_q] = cstop;
                xfer           = ivalid[grant_q] && !cstop;
                if (xfer) begin
                    if (ilast[grant_q] || (cnt_q == CW'(MAXBURST - 1))) begin
                        state_d = ARB_IDLE;
                        cnt_d   = '0;
                        ptr_d   = (grant_q == PW'(NREQ - 1)) ? '0 : grant_q + PW'(1);
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            default: state_d = ARB_IDLE;
        endcase

        if (!reset) begin
            cvalid = 1'b0;
            istop  = '1;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ARB_IDLE;
            grant_q <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

    assign grant_id = grant_q;

endmodule

// File: tb/tb_stream_rr_arb.sv
// Bench for stream_rr_arb: directed scenarios followed by a randomized run,
// all checked cycle by cycle against a behavioural model of the arbiter.
module tb_stream_rr_arb;
    import stream_rr_arb_pkg::*;

    localparam int NREQ = 4;
    localparam int MAXB = 4;

    logic                          clk = 1'b0;
    logic                          reset;
    logic signed [NREQ-1:0][NUM:0] idata;
    logic [NREQ-1:0]               ivalid, ilast, istop;
    logic signed [NUM:0]           cdata;
    logic                          cvalid, clast, cstop, busy;
    logic [1:0]                    grant_id;

    stream_rr_arb #(.NREQ(NREQ), .MAXBURST(MAXB)) dut (
        .clk      (clk),
        .reset    (reset),
        .idata    (idata),
        .ivalid   (ivalid),
        .ilast    (ilast),
        .istop    (istop),
        .cdata    (cdata),
        .cvalid   (cvalid),
        .clast    (clast),
        .cstop    (cstop),
        .grant_id (grant_id),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [NUM:0] d;
        bit           l;
    } beat_t;

    typedef struct {
        int id;
        int d;
        bit l;
        int cyc;
    } rx_t;

    beat_t           srcq[NREQ][$];
    rx_t             rxlog[$];
    logic [NREQ-1:0] gap;
    int              checks = 0;
    int              failures = 0;
    int              cyc = 0;

    // Behavioural model: who owns the consumer, who is next in line,
    // and how many beats the current owner has moved.
    bit m_busy  = 1'b0;
    int m_owner = 0;
    int m_next  = 0;
    int m_beats = 0;

    task automatic chk(input string tag, input logic [NUM:0] obs, input logic [NUM:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic rx_t mk(int id, int d, bit l, int c);
        rx_t r;
        r.id = id; r.d = d; r.l = l; r.cyc = c;
        return r;
    endfunction

    task automatic push_pkt(input int id, input int first, input int len);
        beat_t b;
        for (int k = 0; k < len; k++) begin
            b.d = (NUM+1)'(first + k);
            b.l = (k == len - 1);
            srcq[id].push_back(b);
        end
    endtask

    // One clock: drive sources, check outputs, log transfers, advance model.
    task automatic step();
        logic [NREQ-1:0] e_istop;
        bit              e_cv;
        int              w;
        for (int i = 0; i < NREQ; i++) begin
            ivalid[i] = (srcq[i].size() > 0) && !gap[i];
            idata[i]  = (srcq[i].size() > 0) ? srcq[i][0].d : '0;
            ilast[i]  = (srcq[i].size() > 0) ? srcq[i][0].l : 1'b0;
        end
        #1;
        e_istop = '1;
        e_cv    = 1'b0;
        if (m_busy && reset) begin
            e_cv             = ivalid[m_owner];
            e_istop[m_owner] = cstop;
        end
        chk("istop", istop, e_istop);
        chk("cvalid", cvalid, e_cv);
        chk("busy", busy, m_busy);
        chk("grant_id", grant_id, m_owner);
        if (m_busy) begin
            chk("cdata", cdata, idata[m_owner]);
            chk("clast", clast, ilast[m_owner]);
        end
        if (e_cv && !cstop) begin
            rxlog.push_back(mk(m_owner, int'(srcq[m_owner][0].d), srcq[m_owner][0].l, cyc));
            void'(srcq[m_owner].pop_front());
        end
        if (!reset) begin
            m_busy = 0; m_owner = 0; m_next = 0; m_beats = 0;
        end else if (!m_busy) begin
            w = -1;
            for (int k = NREQ - 1; k >= 0; k--)
                if (ivalid[(m_next + k) % NREQ]) w = (m_next + k) % NREQ;
            if (w >= 0) begin
                m_owner = w; m_beats = 0; m_busy = 1;
            end
        end else if (e_cv && !cstop) begin
            m_beats++;
            if (ilast[m_owner] || m_beats == MAXB) begin
                m_busy  = 0;
                m_beats = 0;
                m_next  = (m_owner + 1) % NREQ;
            end
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic drain(input int limit);
        int  k = 0;
        bit  pending = 1'b1;
        while (pending && k < limit) begin
            pending = m_busy;
            for (int i = 0; i < NREQ; i++) if (srcq[i].size() > 0) pending = 1'b1;
            if (pending) begin
                step();
                k++;
            end
        end
        chk("drain_done", pending, 1'b0);
    endtask

    task automatic step_until_rx(input int n, input int limit);
        int k = 0;
        while (rxlog.size() < n && k < limit) begin
            step();
            k++;
        end
        chk("rx_wait", (rxlog.size() >= n), 1'b1);
    endtask

    task automatic check_log(input string tag, input rx_t exp[$]);
        chk({tag, "_len"}, rxlog.size(), exp.size());
        for (int k = 0; k < exp.size() && k < rxlog.size(); k++) begin
            chk({tag, "_id"}, rxlog[k].id, exp[k].id);
            chk({tag, "_data"}, rxlog[k].d, exp[k].d);
            chk({tag, "_last"}, rxlog[k].l, exp[k].l);
            if (exp[k].cyc >= 0)
                chk({tag, "_cyc"}, rxlog[k].cyc - rxlog[0].cyc, exp[k].cyc);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        rx_t exp[$];
        beat_t b;
        reset  = 1'b0;
        cstop  = 1'b0;
        gap    = '0;
        ivalid = '0;
        ilast  = '0;
        idata  = '0;
        @(posedge clk);
        @(negedge clk);

        // Reset hold with everyone requesting, then round robin of 1-beat packets.
        for (int i = 0; i < NREQ; i++) begin
            push_pkt(i, 100 + i, 1);
            push_pkt(i, 110 + i, 1);
        end
        repeat (3) step();
        reset = 1'b1;
        drain(100);
        exp.delete();
        for (int k = 0; k < 8; k++) exp.push_back(mk(k % 4, (k < 4 ? 100 : 110) + k % 4, 1, 2 * k));
        check_log("rr", exp);

        // Packet lock: req1 keeps the grant for its 3-beat packet.
        rxlog.delete();
        reset = 1'b0; step(); reset = 1'b1;
        push_pkt(1, 10, 3);
        push_pkt(2, 20, 1);
        drain(100);
        exp.delete();
        exp.push_back(mk(1, 10, 0, 0));
        exp.push_back(mk(1, 11, 0, 1));
        exp.push_back(mk(1, 12, 1, 2));
        exp.push_back(mk(2, 20, 1, 4));
        check_log("lock", exp);

        // Backpressure mid-packet on req0.
        rxlog.delete();
        push_pkt(0, 40, 3);
        step_until_rx(1, 20);
        cstop = 1'b1;
        repeat (5) step();
        cstop = 1'b0;
        drain(100);
        exp.delete();
        exp.push_back(mk(0, 40, 0, 0));
        exp.push_back(mk(0, 41, 0, 6));
        exp.push_back(mk(0, 42, 1, 7));
        check_log("stall", exp);

        // Forced rotation after MAXB beats; clast stays with the real last beat.
        rxlog.delete();
        push_pkt(3, 50, 8);
        push_pkt(0, 60, 1);
        drain(100);
        exp.delete();
        for (int k = 0; k < 4; k++) exp.push_back(mk(3, 50 + k, 0, k));
        exp.push_back(mk(0, 60, 1, 5));
        for (int k = 4; k < 8; k++) exp.push_back(mk(3, 50 + k, (k == 7), k + 3));
        check_log("burst", exp);

        // Reset in the middle of a req2 packet; req0 wins after release.
        rxlog.delete();
        push_pkt(2, 70, 4);
        step_until_rx(1, 20);
        reset = 1'b0;
        step();
        reset = 1'b1;
        push_pkt(0, 80, 1);
        drain(100);
        exp.delete();
        exp.push_back(mk(2, 70, 0, 0));
        exp.push_back(mk(0, 80, 1, 3));
        exp.push_back(mk(2, 71, 0, 5));
        exp.push_back(mk(2, 72, 0, 6));
        exp.push_back(mk(2, 73, 1, 7));
        check_log("midrst", exp);

        // Randomized traffic, consumer stalls, valid gaps and rare resets.
        rxlog.delete();
        for (int n = 0; n < 600; n++) begin
            for (int i = 0; i < NREQ; i++) begin
                gap[i] = ($urandom_range(0, 9) < 2);
                if (srcq[i].size() < 3 && $urandom_range(0, 9) < 3) begin
                    int len = $urandom_range(1, 6);
                    for (int k = 0; k < len; k++) begin
                        b.d = (NUM+1)'($urandom);
                        b.l = (k == len - 1);
                        srcq[i].push_back(b);
                    end
                end
            end
            cstop = ($urandom_range(0, 9) < 3);
            reset = ($urandom_range(0, 99) != 0);
            step();
        end
        gap   = '0;
        cstop = 1'b0;
        reset = 1'b1;
        drain(1000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
